// File: rtl/fma16_pkg.sv
// rtl/fma16_pkg.sv - shared flag indices, ctrl word layout and rounding-mode codes for fma16 blocks
package fma16_pkg;

    localparam int FLAG_INEXACT   = 0;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_INVALID   = 3;

    localparam logic [1:0] RZ  = 2'b00;
    localparam logic [1:0] RNE = 2'b01;
    localparam logic [1:0] RM  = 2'b10;
    localparam logic [1:0] RP  = 2'b11;

    typedef struct packed {
        logic [1:0] rsvd;
        logic [1:0] roundmode;
        logic       mul;
        logic       add;
        logic       negp;
        logic       negz;
    } ctrl_t;

    function automatic logic is_nan(input logic [15:0] h);
        return (&h[14:10]) & (|h[9:0]);
    endfunction

    function automatic logic is_snan(input logic [15:0] h);
        return is_nan(h) & ~h[9];
    endfunction

    function automatic logic is_inf(input logic [15:0] h);
        return (&h[14:10]) & ~(|h[9:0]);
    endfunction

    function automatic logic is_zero(input logic [15:0] h);
        return h[14:0] == 15'd0;
    endfunction

endpackage

// File: rtl/fma16.sv
// rtl/fma16.sv - combinational half-precision fused multiply-add with IEEE flags
module fma16
    import fma16_pkg::*;
(
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [15:0] z,
    input  logic        mul,
    input  logic        add,
    input  logic        negp,
    input  logic        negz,
    input  logic [1:0]  roundmode,
    output logic [15:0] result,
    output logic [3:0]  flags
);

    // Exact fixed-point sum in units of 2^-48 covers every product and addend.
    localparam int W = 82;

    logic [15:0]  yy, zz;
    logic         ps, zs, rs;
    logic [4:0]   ex, ey, ez;
    logic [10:0]  mx, my, mz;
    logic [21:0]  prod;
    logic [5:0]   shp, shz;
    logic [W-1:0] pm, zm, mag, low_mask;
    logic [6:0]   lead, s, eb;
    logic         normal, guard, sticky, inexact, up, ovf, ovf_inf;
    logic [11:0]  q_lo, q2;
    logic [16:0]  res;
    logic         any_nan, snan, p_inf, z_inf, p_invalid, inf_diff;

    // Without mul the product is x*1.0; without add the addend is +0.
    assign yy = mul ? y : 16'h3c00;
    assign zz = add ? z : 16'h0000;
    assign ps = x[15] ^ yy[15] ^ negp;
    assign zs = zz[15] ^ negz;

    assign ex = (x[14:10]  == 5'd0) ? 5'd1 : x[14:10];
    assign ey = (yy[14:10] == 5'd0) ? 5'd1 : yy[14:10];
    assign ez = (zz[14:10] == 5'd0) ? 5'd1 : zz[14:10];
    assign mx = {x[14:10]  != 5'd0, x[9:0]};
    assign my = {yy[14:10] != 5'd0, yy[9:0]};
    assign mz = {zz[14:10] != 5'd0, zz[9:0]};

    assign prod = {11'd0, mx} * {11'd0, my};
    assign shp  = {1'b0, ex} + {1'b0, ey} - 6'd2;
    assign shz  = {1'b0, ez} + 6'd23;
    assign pm   = {{(W-22){1'b0}}, prod} << shp;
    assign zm   = {{(W-11){1'b0}}, mz} << shz;

    // Signed-magnitude addition; an exact zero takes +0 except under RM.
    always_comb begin
        mag = '0;
        rs  = ps;
        if (ps == zs) begin
            mag = pm + zm;
        end else if (pm >= zm) begin
            mag = pm - zm;
        end else begin
            mag = zm - pm;
            rs  = zs;
        end
        if (mag == '0 && ps != zs) rs = (roundmode == RM);
    end

    // Leading-one position of the exact sum.
    always_comb begin
        lead = 7'd0;
        for (int i = 0; i < W; i++) begin
            if (mag[i]) lead = 7'(i);
        end
    end

    // Keep 11 significant bits for normals, fixed 2^-24 LSB for subnormals.
    assign normal   = lead >= 7'd34;
    assign s        = normal ? lead - 7'd10 : 7'd24;
    assign q_lo     = 12'(mag >> s);
    assign guard    = mag[s - 7'd1];
    assign low_mask = ({{(W-1){1'b0}}, 1'b1} << (s - 7'd1)) - {{(W-1){1'b0}}, 1'b1};
    assign sticky   = |(mag & low_mask);
    assign inexact  = guard | sticky;

    // Round-increment decision per rounding mode.
    always_comb begin
        case (roundmode)
            RNE:     up = guard & (sticky | q_lo[0]);
            RM:      up = inexact & rs;
            RP:      up = inexact & ~rs;
            default: up = 1'b0;
        endcase
    end

    // Adding the significand (hidden bit included) onto exponent-1 lets a
    // rounding carry bump the exponent, and a subnormal round up into normal.
    assign q2      = q_lo + {11'd0, up};
    assign eb      = normal ? lead - 7'd34 : 7'd0;
    assign res     = {eb, 10'd0} + {5'd0, q2};
    assign ovf     = res >= 17'h07c00;
    assign ovf_inf = (roundmode == RNE) | ((roundmode == RP) & ~rs) | ((roundmode == RM) & rs);

    assign any_nan   = is_nan(x) | is_nan(yy) | is_nan(zz);
    assign snan      = is_snan(x) | is_snan(yy) | is_snan(zz);
    assign p_inf     = is_inf(x) | is_inf(yy);
    assign z_inf     = is_inf(zz);
    assign p_invalid = (is_inf(x) & is_zero(yy)) | (is_zero(x) & is_inf(yy));
    assign inf_diff  = p_inf & z_inf & (ps != zs) & ~any_nan;

    // Special operands take priority over the finite rounding path.
    always_comb begin
        result = 16'h0000;
        flags  = 4'b0000;
        if (any_nan | p_invalid | inf_diff) begin
            result              = 16'h7e00;
            flags[FLAG_INVALID] = snan | p_invalid | inf_diff;
        end else if (p_inf) begin
            result = {ps, 15'h7c00};
        end else if (z_inf) begin
            result = {zs, 15'h7c00};
        end else if (ovf) begin
            result               = {rs, ovf_inf ? 15'h7c00 : 15'h7bff};
            flags[FLAG_OVERFLOW] = 1'b1;
            flags[FLAG_INEXACT]  = 1'b1;
        end else begin
            result                = {rs, res[14:0]};
            flags[FLAG_INEXACT]   = inexact;
            flags[FLAG_UNDERFLOW] = ~normal & inexact;
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin request picker starting the search at ptr
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx
);

    logic found;
    int   j;

    // Walk from ptr upward with wrap; the first pending request wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        j         = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!found && req[j]) begin
                found     = 1'b1;
                grant_idx = IDW'(j);
            end
        end
        if (en && found) grant[grant_idx] = 1'b1;
    end

endmodule

// File: rtl/fma16_arbiter.sv
// rtl/fma16_arbiter.sv - round-robin sharing of one fma16 among NREQ requesters (option: FMA16_ARB_PIPE_EN)
module fma16_arbiter
    import fma16_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ),
    parameter int CNTW = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*16-1:0] req_x,
    input  logic [NREQ*16-1:0] req_y,
    input  logic [NREQ*16-1:0] req_z,
    input  logic [NREQ*8-1:0] req_ctrl,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [15:0]       rsp_result,
    output logic [3:0]        rsp_flags,
    output logic [IDW-1:0]    rsp_id,
    output logic [3:0]        sticky_flags,
    input  logic              flags_clr,
    output logic [CNTW-1:0]   op_count
);

    logic [IDW-1:0]  ptr, grant_idx, load_id;
    logic [NREQ-1:0] grant;
    logic            slot_free, accept, load;
    logic [15:0]     sel_x, sel_y, sel_z, f_x, f_y, f_z, f_result;
    ctrl_t           sel_ctrl, f_ctrl;
    logic [3:0]      f_flags;
    logic            unused_rsvd;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .en        (slot_free),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign accept    = |(req_valid & grant);

    assign sel_x    = req_x[{grant_idx, 4'b0000} +: 16];
    assign sel_y    = req_y[{grant_idx, 4'b0000} +: 16];
    assign sel_z    = req_z[{grant_idx, 4'b0000} +: 16];
    assign sel_ctrl = req_ctrl[{grant_idx, 3'b000} +: 8];

`ifdef FMA16_ARB_PIPE_EN
    logic           pipe_valid, advance;
    logic [15:0]    pipe_x, pipe_y, pipe_z;
    ctrl_t          pipe_ctrl;
    logic [IDW-1:0] pipe_id;

    assign advance   = ~rsp_valid | rsp_ready;
    assign slot_free = ~pipe_valid | advance;
    assign load      = pipe_valid & advance;
    assign f_x       = pipe_x;
    assign f_y       = pipe_y;
    assign f_z       = pipe_z;
    assign f_ctrl    = pipe_ctrl;
    assign load_id   = pipe_id;

    // Input stage captures the granted operation; it empties when it moves on.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_valid <= 1'b0;
            pipe_x     <= '0;
            pipe_y     <= '0;
            pipe_z     <= '0;
            pipe_ctrl  <= '0;
            pipe_id    <= '0;
        end else if (accept) begin
            pipe_valid <= 1'b1;
            pipe_x     <= sel_x;
            pipe_y     <= sel_y;
            pipe_z     <= sel_z;
            pipe_ctrl  <= sel_ctrl;
            pipe_id    <= grant_idx;
        end else if (advance) begin
            pipe_valid <= 1'b0;
        end
    end
`else
    assign slot_free = ~rsp_valid | rsp_ready;
    assign load      = accept;
    assign f_x       = sel_x;
    assign f_y       = sel_y;
    assign f_z       = sel_z;
    assign f_ctrl    = sel_ctrl;
    assign load_id   = grant_idx;
`endif

    assign unused_rsvd = ^f_ctrl.rsvd;

    fma16 u_fma (
        .x         (f_x),
        .y         (f_y),
        .z         (f_z),
        .mul       (f_ctrl.mul),
        .add       (f_ctrl.add),
        .negp      (f_ctrl.negp),
        .negz      (f_ctrl.negz),
        .roundmode (f_ctrl.roundmode),
        .result    (f_result),
        .flags     (f_flags)
    );

    // Pointer moves just past the winner, only when a grant is taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Response slot: load on a new result, otherwise empty on drain; payload holds.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_flags    <= '0;
            rsp_id       <= '0;
            op_count     <= '0;
            sticky_flags <= '0;
        end else begin
            if (load) begin
                rsp_valid  <= 1'b1;
                rsp_result <= f_result;
                rsp_flags  <= f_flags;
                rsp_id     <= load_id;
                op_count   <= op_count + 1'b1;
            end else if (rsp_ready) begin
                rsp_valid <= 1'b0;
            end
            sticky_flags <= (flags_clr ? 4'b0000 : sticky_flags) | (load ? f_flags : 4'b0000);
        end
    end

endmodule

// File: tb/tb_fma16_arbiter.sv
// tb/tb_fma16_arbiter.sv - directed bench with a cycle-level reference model for fma16_arbiter
module tb_fma16_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_x, req_y, req_z;
    logic [31:0] req_ctrl;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic [1:0]  rsp_id;
    logic [3:0]  sticky_flags;
    logic        flags_clr;
    logic [15:0] op_count;

    always #5 clk = ~clk;

    fma16_arbiter #(.NREQ(4), .IDW(2), .CNTW(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_x        (req_x),
        .req_y        (req_y),
        .req_z        (req_z),
        .req_ctrl     (req_ctrl),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_flags    (rsp_flags),
        .rsp_id       (rsp_id),
        .sticky_flags (sticky_flags),
        .flags_clr    (flags_clr),
        .op_count     (op_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Hand-computed vectors: x, y, z, ctrl -> result, {inv,ovf,unf,inx}
    logic [15:0] tx [0:12];
    logic [15:0] ty [0:12];
    logic [15:0] tz [0:12];
    logic [7:0]  tc [0:12];
    logic [15:0] tr [0:12];
    logic [3:0]  tf [0:12];
    int          cur_vec [0:3];

    task automatic setv(input int i, input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                        input logic [7:0] c, input logic [15:0] r, input logic [3:0] f);
        tx[i] = x; ty[i] = y; tz[i] = z; tc[i] = c; tr[i] = r; tf[i] = f;
    endtask

    task automatic set_req(input int r, input int v);
        req_x[16*r +: 16]  = tx[v];
        req_y[16*r +: 16]  = ty[v];
        req_z[16*r +: 16]  = tz[v];
        req_ctrl[8*r +: 8] = tc[v];
        cur_vec[r]         = v;
    endtask

    // Reference model state
    logic        m_valid;
    logic [15:0] m_res;
    logic [3:0]  m_flags;
    int          m_id, m_ptr, m_cnt, mg;
    logic [3:0]  m_sticky, exp_rdy;

    function automatic int rr_pick(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (!reset) begin
                m_valid = 1'b0; m_res = 16'h0; m_flags = 4'h0; m_id = 0;
                m_ptr = 0; m_cnt = 0; m_sticky = 4'h0;
            end else begin
                mg = (!m_valid || rsp_ready) ? rr_pick(req_valid, m_ptr) : -1;
                if (flags_clr) m_sticky = 4'h0;
                if (mg >= 0) begin
                    m_res    = tr[cur_vec[mg]];
                    m_flags  = tf[cur_vec[mg]];
                    m_sticky = m_sticky | m_flags;
                    m_id     = mg;
                    m_valid  = 1'b1;
                    m_ptr    = (mg + 1) % 4;
                    m_cnt    = m_cnt + 1;
                end else if (rsp_ready) begin
                    m_valid = 1'b0;
                end
            end
            #1;
            mg      = (!m_valid || rsp_ready) ? rr_pick(req_valid, m_ptr) : -1;
            exp_rdy = (mg >= 0) ? 4'(1 << mg) : 4'h0;
            check("m_rsp_valid", rsp_valid, m_valid);
            check("m_rsp_result", rsp_result, m_res);
            check("m_rsp_flags", rsp_flags, m_flags);
            check("m_rsp_id", rsp_id, m_id);
            check("m_sticky", sticky_flags, m_sticky);
            check("m_op_count", op_count, 16'(m_cnt));
            check("m_req_ready", req_ready, exp_rdy);
        end
    end

    task automatic do_op(input int r, input int v);
        set_req(r, v);
        req_valid = 4'(1 << r);
        @(negedge clk);
        check("op_valid", rsp_valid, 1);
        check("op_result", rsp_result, tr[v]);
        check("op_flags", rsp_flags, tf[v]);
        check("op_id", rsp_id, r);
        req_valid = 4'h0;
    endtask

    initial begin
        setv(0,  16'h3c00, 16'h3c00, 16'h0000, 8'h18, 16'h3c00, 4'b0000);
        setv(1,  16'h7bff, 16'h4000, 16'h0000, 8'h18, 16'h7c00, 4'b0101);
        setv(2,  16'h3c00, 16'h0000, 16'h3c00, 8'h14, 16'h4000, 4'b0000);
        setv(3,  16'h7c00, 16'h0000, 16'h0000, 8'h18, 16'h7e00, 4'b1000);
        setv(4,  16'h4000, 16'h4200, 16'h0000, 8'h18, 16'h4600, 4'b0000);
        setv(5,  16'h3555, 16'h4200, 16'h0000, 8'h18, 16'h3c00, 4'b0001);
        setv(6,  16'h3555, 16'h4200, 16'h0000, 8'h08, 16'h3bff, 4'b0001);
        setv(7,  16'h4000, 16'h3c00, 16'h0000, 8'h1a, 16'hc000, 4'b0000);
        setv(8,  16'h4000, 16'h4000, 16'hc000, 8'h1c, 16'h4000, 4'b0000);
        setv(9,  16'h4000, 16'h4000, 16'hc000, 8'h1d, 16'h4600, 4'b0000);
        setv(10, 16'h3555, 16'h4200, 16'h0000, 8'h28, 16'h3bff, 4'b0001);
        setv(11, 16'h3555, 16'h4200, 16'h0000, 8'h38, 16'h3c00, 4'b0001);
        setv(12, 16'h0401, 16'h3800, 16'h0000, 8'h18, 16'h0200, 4'b0011);

        req_valid = 4'h0; req_x = '0; req_y = '0; req_z = '0; req_ctrl = '0;
        rsp_ready = 1'b1; flags_clr = 1'b0;
        for (int i = 0; i < 4; i++) cur_vec[i] = 0;

        repeat (3) @(negedge clk);
        check("rst_valid", rsp_valid, 0);
        check("rst_result", rsp_result, 16'h0000);
        check("rst_flags", rsp_flags, 4'h0);
        check("rst_id", rsp_id, 0);
        check("rst_sticky", sticky_flags, 4'h0);
        check("rst_count", op_count, 0);
        reset = 1'b1;
        @(negedge clk);

        do_op(2, 0);
        check("single_count", op_count, 1);
        do_op(1, 1);
        check("ovf_sticky", sticky_flags, 4'b0101);

        set_req(0, 2);
        req_valid = 4'b0001;
        flags_clr = 1'b1;
        @(negedge clk);
        check("clr_result", rsp_result, 16'h4000);
        check("clr_sticky", sticky_flags, 4'b0000);
        flags_clr = 1'b0;
        req_valid = 4'h0;

        do_op(3, 3);
        for (int v = 4; v <= 12; v++) do_op(v % 4, v);

        set_req(1, 4);
        set_req(3, 8);
        rsp_ready = 1'b0;
        req_valid = 4'b1010;
        #1;
        check("bp_ready0", req_ready, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_ready", req_ready, 4'b0000);
            check("bp_valid", rsp_valid, 1);
            check("bp_id", rsp_id, 0);
            check("bp_result", rsp_result, 16'h0200);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready", req_ready, 4'b0010);
        @(negedge clk);
        check("bp_drain_valid", rsp_valid, 1);
        check("bp_drain_id", rsp_id, 1);
        check("bp_drain_result", rsp_result, 16'h4600);

        reset = 1'b0;
        #1;
        check("mid_rst_valid", rsp_valid, 0);
        check("mid_rst_sticky", sticky_flags, 4'h0);
        check("mid_rst_count", op_count, 0);
        @(negedge clk);
        set_req(0, 4);
        set_req(1, 5);
        set_req(2, 7);
        set_req(3, 8);
        req_valid = 4'hf;
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("fair_valid", rsp_valid, 1);
            check("fair_id", rsp_id, k % 4);
            check("fair_count", op_count, k + 1);
        end
        req_valid = 4'h0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
